// File: rtl/gfx_pkg.sv
// Shared geometry, widths and capture-state encoding for the rasterizer
// frame capture path.
package gfx_pkg;

  localparam int FB_W  = 8;
  localparam int FB_H  = 8;
  localparam int PIX_W = 4;
  localparam int NPIX  = FB_W * FB_H;
  localparam int ROW_W = $clog2(FB_H);
  localparam int IDX_W = $clog2(NPIX);
  localparam int CNT_W = $clog2(NPIX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALIGN   = 2'd1,
    CAPTURE = 2'd2
  } cap_state_e;

  function automatic logic pix_lit(input logic [PIX_W-1:0] pix);
    return |pix;
  endfunction

endpackage

// File: rtl/frame_capture_sink_if.sv
// Pixel stream, row-read port and frame status bundle between the
// rasterizer/display side (master) and the capture sink (slave).
interface frame_capture_sink_if;
  import gfx_pkg::*;

  logic             frame_start;
  logic [PIX_W-1:0] pixel_data;
  logic             rd_en;
  logic [ROW_W-1:0] rd_row;
  logic [FB_W-1:0]  rd_data;
  logic             rd_valid;
  logic             frame_done;
  logic             frame_abort;
  logic             capture_busy;
  logic [CNT_W-1:0] lit_count;
  logic [7:0]       frame_count;

  modport master (
    output frame_start, pixel_data, rd_en, rd_row,
    input  rd_data, rd_valid, frame_done, frame_abort, capture_busy,
           lit_count, frame_count
  );

  modport slave (
    input  frame_start, pixel_data, rd_en, rd_row,
    output rd_data, rd_valid, frame_done, frame_abort, capture_busy,
           lit_count, frame_count
  );

endinterface

// File: rtl/frame_capture_bank.sv
// Work/display 8x8 bit buffers: single-bit writes into the work buffer,
// whole-frame commit to the display buffer, and a registered row read.
module frame_capture_bank
  import gfx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_bit,
  input  logic             i_commit,
  input  logic             i_rd_en,
  input  logic [ROW_W-1:0] i_rd_row,
  output logic [FB_W-1:0]  o_rd_data,
  output logic             o_rd_valid
);

  logic [NPIX-1:0] r_work;
  logic [NPIX-1:0] w_work_next;
  logic [FB_W-1:0] r_display [FB_H];

  // Commit copies the post-write work image so the final pixel is included.
  always_comb begin
    w_work_next = r_work;
    if (i_wr_en) begin
      w_work_next[i_wr_idx] = i_wr_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
    end else begin
      r_work <= w_work_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FB_H; gi++) begin : g_row
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_display[gi] <= '0;
        end else if (i_commit) begin
          r_display[gi] <= w_work_next[gi*FB_W +: FB_W];
        end
      end
    end
  endgenerate

  // Reads see the display contents from before any commit on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        o_rd_data <= r_display[i_rd_row];
      end
    end
  end

endmodule

// File: rtl/frame_capture_sink.sv
// Captures 64-pixel frames from the rasterizer stream into a double-buffered
// 8x8 lit map and publishes per-frame statistics.
module frame_capture_sink
  import gfx_pkg::*;
#(
  parameter int PIXEL_LAG = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  frame_capture_sink_if.slave bus
);

  // Pixel 0 lands PIXEL_LAG edges after the start edge; lags 0 and 1 both
  // go straight to CAPTURE, larger lags spend PIXEL_LAG-1 cycles in ALIGN.
  localparam logic [1:0]       LAG_LOAD = (PIXEL_LAG > 1) ? 2'(PIXEL_LAG - 1) : 2'd0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

  cap_state_e       r_state, w_state_next;
  logic [1:0]       r_lag, w_lag_next;
  logic [IDX_W-1:0] r_pix_idx, w_pix_idx_next;
  logic [CNT_W-1:0] r_acc, w_acc_next;
  logic [CNT_W-1:0] r_lit_count, w_lit_count_next;
  logic [7:0]       r_frame_count, w_frame_count_next;
  logic             r_frame_done, w_frame_done_next;
  logic             r_frame_abort, w_frame_abort_next;
  logic             r_busy;
  logic             w_start;
  logic             w_wr_en;
  logic             w_commit;
  logic             w_lit;
  logic [CNT_W-1:0] w_lit_ext;

  assign w_lit     = pix_lit(bus.pixel_data);
  assign w_lit_ext = {{(CNT_W-1){1'b0}}, w_lit};

  always_comb begin
    w_state_next       = r_state;
    w_lag_next         = r_lag;
    w_pix_idx_next     = r_pix_idx;
    w_acc_next         = r_acc;
    w_lit_count_next   = r_lit_count;
    w_frame_count_next = r_frame_count;
    w_frame_done_next  = 1'b0;
    w_frame_abort_next = 1'b0;
    w_start            = 1'b0;
    w_wr_en            = 1'b0;
    w_commit           = 1'b0;

    case (r_state)
      IDLE: begin
        w_start = bus.frame_start;
      end
      ALIGN: begin
        if (bus.frame_start) begin
          w_frame_abort_next = 1'b1;
          w_start            = 1'b1;
        end else begin
          w_lag_next = r_lag - 2'd1;
          if (r_lag <= 2'd1) begin
            w_state_next = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (r_pix_idx == LAST_IDX) begin
          // A start on the final pixel chains into the next frame, no abort.
          w_wr_en            = 1'b1;
          w_commit           = 1'b1;
          w_lit_count_next   = r_acc + w_lit_ext;
          w_frame_count_next = r_frame_count + 8'd1;
          w_frame_done_next  = 1'b1;
          w_state_next       = IDLE;
          w_pix_idx_next     = '0;
          w_acc_next         = '0;
          w_start            = bus.frame_start;
        end else if (bus.frame_start) begin
          w_frame_abort_next = 1'b1;
          w_start            = 1'b1;
        end else begin
          w_wr_en        = 1'b1;
          w_pix_idx_next = r_pix_idx + 1'b1;
          w_acc_next     = r_acc + w_lit_ext;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    if (w_start) begin
      w_pix_idx_next = '0;
      w_acc_next     = '0;
      w_lag_next     = LAG_LOAD;
      w_state_next   = (PIXEL_LAG <= 1) ? CAPTURE : ALIGN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_lag         <= '0;
      r_pix_idx     <= '0;
      r_acc         <= '0;
      r_lit_count   <= '0;
      r_frame_count <= '0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_lag         <= w_lag_next;
      r_pix_idx     <= w_pix_idx_next;
      r_acc         <= w_acc_next;
      r_lit_count   <= w_lit_count_next;
      r_frame_count <= w_frame_count_next;
      r_frame_done  <= w_frame_done_next;
      r_frame_abort <= w_frame_abort_next;
      r_busy        <= (w_state_next != IDLE);
    end
  end

  frame_capture_bank u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (r_pix_idx),
    .i_wr_bit   (w_lit),
    .i_commit   (w_commit),
    .i_rd_en    (bus.rd_en),
    .i_rd_row   (bus.rd_row),
    .o_rd_data  (bus.rd_data),
    .o_rd_valid (bus.rd_valid)
  );

  assign bus.frame_done   = r_frame_done;
  assign bus.frame_abort  = r_frame_abort;
  assign bus.capture_busy = r_busy;
  assign bus.lit_count    = r_lit_count;
  assign bus.frame_count  = r_frame_count;

endmodule

// File: tb/tb_frame_capture_sink.sv
// Scoreboard bench for frame_capture_sink: directed frames push expected
// reads/commits into queues, a negedge monitor pops and compares them.
module tb_frame_capture_sink;
  import gfx_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_capture_sink_if bus ();

  frame_capture_sink #(.PIXEL_LAG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int lit;
    int fc;
  } done_t;

  int         checks = 0;
  int         errors = 0;
  int         abort_seen = 0;
  logic [7:0] exp_rd_q[$];
  done_t      exp_done_q[$];
  logic [3:0] frame_pix [64];
  logic [7:0] exp_rows [8];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Monitor: every rd_valid / frame_done pops one expected entry.
  initial begin : monitor
    logic [7:0] e;
    done_t      d;
    forever begin
      @(negedge clk);
      if (bus.frame_abort) begin
        abort_seen++;
        $display("abort  t=%0t", $time);
      end
      if (bus.rd_valid) begin
        if (exp_rd_q.size() == 0) begin
          chk("rd_valid_unexpected", 1, 0);
        end else begin
          e = exp_rd_q.pop_front();
          $display("read   data=0x%02h expect=0x%02h", bus.rd_data, e);
          chk("rd_data", int'(bus.rd_data), int'(e));
        end
      end
      if (bus.frame_done) begin
        if (exp_done_q.size() == 0) begin
          chk("frame_done_unexpected", 1, 0);
        end else begin
          d = exp_done_q.pop_front();
          $display("done   lit=%0d count=%0d", bus.lit_count, bus.frame_count);
          chk("lit_count", int'(bus.lit_count), d.lit);
          chk("frame_count", int'(bus.frame_count), d.fc);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_done(input int lit, input int fc);
    done_t d;
    d.lit = lit;
    d.fc  = fc;
    exp_done_q.push_back(d);
  endtask

  task automatic fill_pix(input logic [3:0] v);
    for (int k = 0; k < 64; k++) frame_pix[k] = v;
  endtask

  task automatic set_rows(input logic [7:0] v);
    for (int r = 0; r < 8; r++) exp_rows[r] = v;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.pixel_data  = '0;
    bus.rd_en       = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drive_start();
    @(negedge clk);
    bus.frame_start = 1'b1;
    bus.rd_en       = 1'b0;
  endtask

  // Back-to-back row reads 0..7 against exp_rows.
  task automatic read_all();
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      bus.frame_start = 1'b0;
      bus.rd_en       = 1'b1;
      bus.rd_row      = 3'(r);
      exp_rd_q.push_back(exp_rows[r]);
    end
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic drive_pixels(input int n, input bit fs_last,
                              input bit rd_first, input logic [7:0] exp_first,
                              input bit rd_last, input logic [7:0] exp_last);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_in_capture", int'(bus.capture_busy), 1);
      bus.frame_start = fs_last && (k == n - 1);
      bus.pixel_data  = frame_pix[k];
      bus.rd_en       = 1'b0;
      if (rd_first && k == 0) begin
        bus.rd_en  = 1'b1;
        bus.rd_row = 3'd0;
        exp_rd_q.push_back(exp_first);
      end
      if (rd_last && k == n - 1) begin
        bus.rd_en  = 1'b1;
        bus.rd_row = 3'd0;
        exp_rd_q.push_back(exp_last);
      end
    end
  endtask

  initial begin : stimulus
    bus.frame_start = 1'b0;
    bus.pixel_data  = '0;
    bus.rd_en       = 1'b0;
    bus.rd_row      = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rd_valid", int'(bus.rd_valid), 0);
    chk("rst_rd_data", int'(bus.rd_data), 0);
    chk("rst_lit_count", int'(bus.lit_count), 0);
    chk("rst_frame_count", int'(bus.frame_count), 0);
    chk("rst_busy", int'(bus.capture_busy), 0);
    chk("rst_done", int'(bus.frame_done), 0);
    set_rows(8'h00);
    read_all();

    // Single lit pixel at (2,5)
    fill_pix(4'h0);
    frame_pix[2*8+5] = 4'h1;
    push_done(1, 1);
    drive_start();
    drive_pixels(64, 0, 0, 8'h00, 0, 8'h00);
    idle(3);
    chk("busy_after_frame", int'(bus.capture_busy), 0);
    set_rows(8'h00);
    exp_rows[2] = 8'h20;
    read_all();

    // Fully lit frame
    fill_pix(4'hF);
    push_done(64, 2);
    drive_start();
    drive_pixels(64, 0, 0, 8'h00, 0, 8'h00);
    idle(3);
    set_rows(8'hFF);
    read_all();

    // Abort after 20 pixels, then checkerboard
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        frame_pix[r*8+c] = ((r + c) % 2 == 1) ? 4'h3 : 4'h0;
    drive_start();
    drive_pixels(20, 0, 0, 8'h00, 0, 8'h00);
    set_rows(8'hFF);
    read_all();
    push_done(32, 3);
    drive_start();
    drive_pixels(64, 0, 0, 8'h00, 0, 8'h00);
    idle(3);
    chk("abort_pulses", abort_seen, 1);
    for (int r = 0; r < 8; r++) exp_rows[r] = (r % 2 == 0) ? 8'hAA : 8'h55;
    read_all();
    idle(2);
    chk("rd_data_hold", int'(bus.rd_data), 8'h55);
    chk("rd_valid_low", int'(bus.rd_valid), 0);

    // Start on the pixel-63 edge chains frames; read around the commit edge
    fill_pix(4'h0);
    frame_pix[0] = 4'h8;
    push_done(1, 4);
    push_done(64, 5);
    drive_start();
    drive_pixels(64, 1, 0, 8'h00, 1, 8'hAA);
    fill_pix(4'hF);
    drive_pixels(64, 0, 1, 8'h01, 0, 8'h00);
    idle(3);
    chk("no_abort_on_chain", abort_seen, 1);
    set_rows(8'hFF);
    read_all();

    // Asynchronous reset in the middle of a capture
    fill_pix(4'hF);
    drive_start();
    drive_pixels(30, 0, 0, 8'h00, 0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_data", int'(bus.rd_data), 0);
    chk("arst_lit_count", int'(bus.lit_count), 0);
    chk("arst_frame_count", int'(bus.frame_count), 0);
    chk("arst_busy", int'(bus.capture_busy), 0);
    chk("arst_done", int'(bus.frame_done), 0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    chk("busy_after_arst", int'(bus.capture_busy), 0);
    set_rows(8'h00);
    read_all();

    // 256 chained empty frames: frame_count wraps back to 0
    fill_pix(4'h0);
    for (int i = 0; i < 256; i++) push_done(0, (i + 1) % 256);
    drive_start();
    for (int i = 0; i < 256; i++) drive_pixels(64, i != 255, 0, 8'h00, 0, 8'h00);
    idle(3);
    chk("wrap_frame_count", int'(bus.frame_count), 0);
    chk("wrap_lit_count", int'(bus.lit_count), 0);
    chk("abort_total", abort_seen, 1);

    idle(2);
    chk("rd_queue_drained", exp_rd_q.size(), 0);
    chk("done_queue_drained", exp_done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
